// File: rtl/axi_resp_packer_pkg.sv
// ----------------------------------------------------------------------------
// axi_resp_packer_pkg
//   Shared widths, FIFO depths and AXI return-channel payload types for the
//   memory-controller-to-AXI response packer.
//   axi_r_chan_t : {data, user, id, last}  (70 bits)
//   axi_b_chan_t : {user, id}              (5 bits)
// ----------------------------------------------------------------------------
package axi_resp_packer_pkg;

    localparam int MEM_DATAWIDTH = 64;
    localparam int MEM_IDWIDTH   = 4;
    localparam int MEM_USERWIDTH = 1;
    localparam int BURST_LENGTH  = 8;

    // Return-path buffering
    localparam int RESPFIFODEPTH = 16;
    localparam int ACKFIFODEPTH  = 4;

    typedef struct packed {
        logic [MEM_DATAWIDTH-1:0] data;
        logic [MEM_USERWIDTH-1:0] user;
        logic [MEM_IDWIDTH-1:0]   id;
        logic                     last;
    } axi_r_chan_t;

    typedef struct packed {
        logic [MEM_USERWIDTH-1:0] user;
        logic [MEM_IDWIDTH-1:0]   id;
    } axi_b_chan_t;

endpackage

// File: rtl/axi_resp_packer_resp_fifo.sv
// ----------------------------------------------------------------------------
// resp_fifo
//   Synchronous FIFO with a registered head entry. The head is read straight
//   out of the storage flops, so a push in cycle N is visible at the output in
//   cycle N+1 at the earliest; there is no write-to-read bypass.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     push         write push_data this cycle (ignored while full)
//     push_data    entry to store
//     full         no free slot; a pop while full frees a slot next cycle
//     pop          remove the head this cycle (ignored while empty)
//     head         oldest entry (zero after reset)
//     empty        no entry stored
//
//   Pointers are log2(DEPTH)+1 bits and wrap naturally; the extra MSB
//   distinguishes full (MSBs differ, index bits equal) from empty (equal).
// ----------------------------------------------------------------------------
module resp_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_data,
    output logic full,
    input  logic pop,
    output T     head,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // full/empty come only from the pointers, so the space seen by the writer
    // never depends on the reader's same-cycle pop.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/axi_resp_packer.sv
// ----------------------------------------------------------------------------
// axi_resp_packer
//   Return-path bridge from the memory-controller response side to the AXI
//   R and B channels. Read beats and write acks are buffered in independent
//   FIFOs. R.last is regenerated from a per-burst beat counter; a disagreement
//   between the MC-side last marker and the counter sets a sticky error.
//
//   Handshake: every channel transfers on a cycle where valid && ready are
//   both high. Once valid is raised it stays high and its payload stays
//   unchanged until the transfer happens.
//
//   Ports
//     clk, rst_n                      clock, asynchronous active-low reset
//     mc_r_valid/data/id/user/last    MC read beat
//     mc_r_ready                      read FIFO has space
//     mc_b_valid/id/user              MC write ack
//     mc_b_ready                      ack FIFO has space
//     axi_r, axi_r_valid, axi_r_ready AXI R channel {data,user,id,last}
//     axi_b, axi_b_valid, axi_b_ready AXI B channel {user,id}
//     err_last                        sticky MC-last vs beat-counter mismatch
// ----------------------------------------------------------------------------
module axi_resp_packer
    import axi_resp_packer_pkg::*;
#(
    parameter int RFIFO_DEPTH = RESPFIFODEPTH,
    parameter int BFIFO_DEPTH = ACKFIFODEPTH,
    parameter int BEATS       = BURST_LENGTH
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     mc_r_valid,
    input  logic [MEM_DATAWIDTH-1:0] mc_r_data,
    input  logic [MEM_IDWIDTH-1:0]   mc_r_id,
    input  logic [MEM_USERWIDTH-1:0] mc_r_user,
    input  logic                     mc_r_last,
    output logic                     mc_r_ready,

    input  logic                     mc_b_valid,
    input  logic [MEM_IDWIDTH-1:0]   mc_b_id,
    input  logic [MEM_USERWIDTH-1:0] mc_b_user,
    output logic                     mc_b_ready,

    output axi_r_chan_t              axi_r,
    output logic                     axi_r_valid,
    input  logic                     axi_r_ready,

    output axi_b_chan_t              axi_b,
    output logic                     axi_b_valid,
    input  logic                     axi_b_ready,

    output logic                     err_last
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic          rfifo_full;
    logic          rfifo_empty;
    logic          r_push;
    logic          r_pop;
    logic [CW-1:0] beat_cnt;
    logic          beat_last;
    axi_r_chan_t   r_entry;

    assign mc_r_ready = !rfifo_full;
    assign r_push     = mc_r_valid && mc_r_ready;
    assign r_pop      = axi_r_valid && axi_r_ready;
    assign axi_r_valid = !rfifo_empty;

    // The stored last comes only from the counter; mc_r_last is used solely
    // as a cross-check so a misbehaving MC cannot corrupt burst framing.
    assign beat_last = (beat_cnt == CW'(BEATS - 1));

    always_comb begin
        r_entry      = '0;
        r_entry.data = mc_r_data;
        r_entry.user = mc_r_user;
        r_entry.id   = mc_r_id;
        r_entry.last = beat_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            err_last <= 1'b0;
        end else if (r_push) begin
            beat_cnt <= beat_last ? '0 : beat_cnt + CW'(1);
            if (mc_r_last != beat_last) begin
                err_last <= 1'b1;
            end
        end
    end

    resp_fifo #(
        .T     (axi_r_chan_t),
        .DEPTH (RFIFO_DEPTH)
    ) u_rfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_push),
        .push_data (r_entry),
        .full      (rfifo_full),
        .pop       (r_pop),
        .head      (axi_r),
        .empty     (rfifo_empty)
    );

    // ------------------------------------------------------------------
    // Write-ack path (no shared state with the read path)
    // ------------------------------------------------------------------
    logic        bfifo_full;
    logic        bfifo_empty;
    logic        b_push;
    logic        b_pop;
    axi_b_chan_t b_entry;

    assign mc_b_ready  = !bfifo_full;
    assign b_push      = mc_b_valid && mc_b_ready;
    assign b_pop       = axi_b_valid && axi_b_ready;
    assign axi_b_valid = !bfifo_empty;

    always_comb begin
        b_entry      = '0;
        b_entry.user = mc_b_user;
        b_entry.id   = mc_b_id;
    end

    resp_fifo #(
        .T     (axi_b_chan_t),
        .DEPTH (BFIFO_DEPTH)
    ) u_bfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (b_push),
        .push_data (b_entry),
        .full      (bfifo_full),
        .pop       (b_pop),
        .head      (axi_b),
        .empty     (bfifo_empty)
    );

endmodule

// File: tb/tb_axi_resp_packer.sv
// ----------------------------------------------------------------------------
// tb_axi_resp_packer
//   Self-checking bench for axi_resp_packer. Inputs change 1 time unit after
//   the rising edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_axi_resp_packer;
    import axi_resp_packer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        mc_r_valid = 1'b0;
    logic [63:0] mc_r_data = '0;
    logic [3:0]  mc_r_id = '0;
    logic [0:0]  mc_r_user = '0;
    logic        mc_r_last = 1'b0;
    logic        mc_r_ready;
    logic        mc_b_valid = 1'b0;
    logic [3:0]  mc_b_id = '0;
    logic [0:0]  mc_b_user = '0;
    logic        mc_b_ready;
    axi_r_chan_t axi_r;
    logic        axi_r_valid;
    logic        axi_r_ready = 1'b0;
    axi_b_chan_t axi_b;
    logic        axi_b_valid;
    logic        axi_b_ready = 1'b0;
    logic        err_last;

    axi_resp_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mc_r_valid  (mc_r_valid),
        .mc_r_data   (mc_r_data),
        .mc_r_id     (mc_r_id),
        .mc_r_user   (mc_r_user),
        .mc_r_last   (mc_r_last),
        .mc_r_ready  (mc_r_ready),
        .mc_b_valid  (mc_b_valid),
        .mc_b_id     (mc_b_id),
        .mc_b_user   (mc_b_user),
        .mc_b_ready  (mc_b_ready),
        .axi_r       (axi_r),
        .axi_r_valid (axi_r_valid),
        .axi_r_ready (axi_r_ready),
        .axi_b       (axi_b),
        .axi_b_valid (axi_b_valid),
        .axi_b_ready (axi_b_ready),
        .err_last    (err_last)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [69:0] exp_r_q[$];
    logic [4:0]  exp_b_q[$];

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic        r_stall_prev = 1'b0;
    logic        b_stall_prev = 1'b0;
    logic [69:0] r_prev = '0;
    logic [4:0]  b_prev = '0;

    // Output monitor: pops expectations on each accepted transfer and checks
    // that a stalled valid keeps both valid and payload.
    always @(negedge clk) begin
        if (!rst_n) begin
            r_stall_prev = 1'b0;
            b_stall_prev = 1'b0;
        end else begin
            if (r_stall_prev) begin
                check("r_hold_valid", 70'(axi_r_valid), 70'(1));
                check("r_hold_payload", axi_r, r_prev);
            end
            if (b_stall_prev) begin
                check("b_hold_valid", 70'(axi_b_valid), 70'(1));
                check("b_hold_payload", 70'(axi_b), 70'(b_prev));
            end
            if (axi_r_valid && axi_r_ready) begin
                if (exp_r_q.size() == 0) begin
                    check("r_unexpected_beat", 70'(1), 70'(0));
                end else begin
                    check("r_beat", axi_r, exp_r_q.pop_front());
                end
            end
            if (axi_b_valid && axi_b_ready) begin
                if (exp_b_q.size() == 0) begin
                    check("b_unexpected_ack", 70'(1), 70'(0));
                end else begin
                    check("b_ack", 70'(axi_b), 70'(exp_b_q.pop_front()));
                end
            end
            r_stall_prev = axi_r_valid && !axi_r_ready;
            b_stall_prev = axi_b_valid && !axi_b_ready;
            r_prev = axi_r;
            b_prev = axi_b;
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns 1 unit after the accepting edge.
    task automatic r_beat(input logic [63:0] d, input logic [3:0] id, input logic u,
                          input logic mc_last, input logic exp_last);
        int t = 0;
        mc_r_valid = 1'b1;
        mc_r_data  = d;
        mc_r_id    = id;
        mc_r_user  = u;
        mc_r_last  = mc_last;
        @(negedge clk);
        while (!mc_r_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!mc_r_ready) check("r_push_timeout", 70'(0), 70'(1));
        else exp_r_q.push_back({d, u, id, exp_last});
        @(posedge clk);
        #1;
        mc_r_valid = 1'b0;
    endtask

    task automatic b_beat(input logic [3:0] id, input logic u);
        int t = 0;
        mc_b_valid = 1'b1;
        mc_b_id    = id;
        mc_b_user  = u;
        @(negedge clk);
        while (!mc_b_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!mc_b_ready) check("b_push_timeout", 70'(0), 70'(1));
        else exp_b_q.push_back({u, id});
        @(posedge clk);
        #1;
        mc_b_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_r_q.size() != 0 || exp_b_q.size() != 0) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", 70'(exp_r_q.size() + exp_b_q.size()), 70'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        mc_r_valid = 1'b0;
        mc_b_valid = 1'b0;
        exp_r_q.delete();
        exp_b_q.delete();
        #1;
        check("rst_r_valid", 70'(axi_r_valid), 70'(0));
        check("rst_b_valid", 70'(axi_b_valid), 70'(0));
        check("rst_r_ready", 70'(mc_r_ready), 70'(1));
        check("rst_b_ready", 70'(mc_b_ready), 70'(1));
        check("rst_r_payload", axi_r, 70'(0));
        check("rst_b_payload", 70'(axi_b), 70'(0));
        check("rst_err_last", 70'(err_last), 70'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic [63:0] data;
        logic [3:0]  id;
        logic        user;
        logic        mc_last;
        logic        exp_last;
        logic        exp_err;
    } r_vec_t;

    r_vec_t vec_burst[8];
    r_vec_t vec_badlast[8];
    r_vec_t vec_after_rst[8];

    bit r_done;
    bit b_done;

    initial begin
        for (int i = 0; i < 8; i++) begin
            vec_burst[i]     = '{64'h10 + 64'(i), 4'd3, i[0], (i == 7), (i == 7), 1'b0};
            vec_badlast[i]   = '{64'hA0 + 64'(i), 4'd9, 1'b0, (i == 3 || i == 7), (i == 7), (i >= 3)};
            vec_after_rst[i] = '{64'hC0 + 64'(i), 4'd4, 1'b1, (i == 7), (i == 7), 1'b0};
        end

        // Initial reset
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check("idle_r_valid", 70'(axi_r_valid), 70'(0));

        // 1: one clean burst, ready always high
        axi_r_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r_beat(vec_burst[i].data, vec_burst[i].id, vec_burst[i].user,
                   vec_burst[i].mc_last, vec_burst[i].exp_last);
            if (i == 0) check("r_valid_next_cycle", 70'(axi_r_valid), 70'(1));
            check("burst_err", 70'(err_last), 70'(vec_burst[i].exp_err));
        end
        drain();

        // 2: fill the read FIFO with 16 beats, hold the 17th
        axi_r_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            r_beat(64'h200 + 64'(i), 4'd2, 1'b0, (i % 8 == 7), (i % 8 == 7));
        end
        check("r_full_ready", 70'(mc_r_ready), 70'(0));
        mc_r_valid = 1'b1;
        mc_r_data  = 64'h210;
        mc_r_id    = 4'd2;
        mc_r_user  = 1'b0;
        mc_r_last  = 1'b0;
        @(negedge clk);
        check("r_full_hold", 70'(mc_r_ready), 70'(0));
        check("r_head_first", axi_r, {64'h200, 1'b0, 4'd2, 1'b0});
        @(posedge clk);
        #1;
        axi_r_ready = 1'b1;
        @(posedge clk);
        #1;
        axi_r_ready = 1'b0;
        check("r_ready_after_pop", 70'(mc_r_ready), 70'(1));
        @(negedge clk);
        if (mc_r_valid && mc_r_ready) exp_r_q.push_back({64'h210, 1'b0, 4'd2, 1'b0});
        @(posedge clk);
        #1;
        mc_r_valid = 1'b0;
        check("r_full_again", 70'(mc_r_ready), 70'(0));
        axi_r_ready = 1'b1;
        drain();

        // 3: MC last on beat 3 sets sticky error; R.last stays on beat 7
        do_reset();
        axi_r_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r_beat(vec_badlast[i].data, vec_badlast[i].id, vec_badlast[i].user,
                   vec_badlast[i].mc_last, vec_badlast[i].exp_last);
            check("badlast_err", 70'(err_last), 70'(vec_badlast[i].exp_err));
        end
        drain();

        // 4: acks fill the 4-deep B FIFO, then drain with toggling ready
        axi_b_ready = 1'b0;
        b_beat(4'd1, 1'b0);
        b_beat(4'd2, 1'b1);
        b_beat(4'd5, 1'b0);
        b_beat(4'd6, 1'b1);
        check("b_full_ready", 70'(mc_b_ready), 70'(0));
        for (int i = 0; i < 12; i++) begin
            axi_b_ready = (i % 2 == 0);
            @(posedge clk);
            #1;
        end
        axi_b_ready = 1'b1;
        drain();

        // 5: concurrent R and B traffic with random readies and gaps
        r_done = 1'b0;
        b_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    r_beat({32'(i), $urandom()}, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                           (i % 8 == 7), (i % 8 == 7));
                end
                r_done = 1'b1;
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    b_beat(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                end
                b_done = 1'b1;
            end
            begin
                while (!(r_done && b_done)) begin
                    axi_r_ready = 1'($urandom_range(0, 1));
                    axi_b_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        axi_r_ready = 1'b1;
        axi_b_ready = 1'b1;
        drain();
        check("err_sticky", 70'(err_last), 70'(1));

        // 6: reset after beat 4 of a burst, then a fresh burst
        axi_r_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r_beat(64'hB0 + 64'(i), 4'd8, 1'b0, 1'b0, 1'b0);
        end
        do_reset();
        axi_r_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r_beat(vec_after_rst[i].data, vec_after_rst[i].id, vec_after_rst[i].user,
                   vec_after_rst[i].mc_last, vec_after_rst[i].exp_last);
            check("after_rst_err", 70'(err_last), 70'(vec_after_rst[i].exp_err));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
